// File: rtl/change_return_dispenser_pkg.sv
// Shared definitions for the coin-return path: widths, coin values and FSM encoding.
package change_return_dispenser_pkg;

  localparam int kNumCoins  = 3;
  localparam int kNumItems  = 4;
  localparam int kTotalBits = 31;
  localparam int kWaitTime  = 10;

  typedef logic [kTotalBits-1:0] total_t;
  typedef logic [kNumCoins-1:0]  coin_vec_t;

  // Ascending denominations; index matches the one-hot coin bit.
  localparam total_t kCoinValue [kNumCoins] = '{31'd100, 31'd500, 31'd1000};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RETURN = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic total_t coin_amount(input coin_vec_t onehot);
    coin_amount = '0;
    for (int k = 0; k < kNumCoins; k++) begin
      if (onehot[k]) coin_amount = coin_amount | kCoinValue[k];
    end
  endfunction

endpackage

// File: rtl/change_return_dispenser_coin_picker.sv
// Combinational selector of the largest coin that fits into a balance.
module change_return_dispenser_coin_picker
  import change_return_dispenser_pkg::*;
(
  input  logic [kTotalBits-1:0] balance,
  output logic [kNumCoins-1:0]  coin,
  output logic                  fits
);

  // Later (larger) denominations override earlier matches.
  always_comb begin
    coin = '0;
    fits = 1'b0;
    for (int k = 0; k < kNumCoins; k++) begin
      if (kCoinValue[k] <= balance) begin
        coin    = '0;
        coin[k] = 1'b1;
        fits    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_return_dispenser.sv
// Coin-return producer: idle timeout / explicit request, then greedy payout one coin per cycle.
module change_return_dispenser
  import change_return_dispenser_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [kNumCoins-1:0]  i_input_coin,
  input  logic [kNumItems-1:0]  i_select_item,
  input  logic                  i_trigger_return,
  input  logic [kTotalBits-1:0] current_total,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [kTotalBits-1:0] o_residue,
  output logic [31:0]           wait_time
);

  state_t               state_q, state_d;
  total_t               balance_q, balance_d;
  coin_vec_t            coin_d;
  logic                 busy_d, done_d;
  total_t               residue_d;
  logic [31:0]          wait_d;
  coin_vec_t            coin_sel;
  logic                 coin_fits;
  logic                 activity;
  logic                 start;

  change_return_dispenser_coin_picker u_picker (
    .balance (balance_q),
    .coin    (coin_sel),
    .fits    (coin_fits)
  );

  assign activity = (|i_input_coin) || (|i_select_item);
  // Trigger beats simultaneous activity; a zero balance never starts a payout.
  assign start    = (current_total != '0) &&
                    (i_trigger_return || (wait_time == 32'(kWaitTime)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      balance_q     <= '0;
      o_return_coin <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_residue     <= '0;
      wait_time     <= '0;
    end else begin
      state_q       <= state_d;
      balance_q     <= balance_d;
      o_return_coin <= coin_d;
      o_busy        <= busy_d;
      o_done        <= done_d;
      o_residue     <= residue_d;
      wait_time     <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RETURN;
      RETURN:  if (!coin_fits) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    balance_d = balance_q;
    coin_d    = '0;
    busy_d    = o_busy;
    done_d    = 1'b0;
    residue_d = o_residue;
    wait_d    = wait_time;
    case (state_q)
      IDLE: begin
        if ((current_total == '0) || activity) begin
          wait_d = '0;
        end else if (wait_time < 32'(kWaitTime)) begin
          wait_d = wait_time + 32'd1;
        end
        if (start) begin
          balance_d = current_total;
          busy_d    = 1'b1;
          residue_d = '0;
        end
      end
      RETURN: begin
        if (coin_fits) begin
          coin_d    = coin_sel;
          balance_d = balance_q - coin_amount(coin_sel);
        end else begin
          residue_d = balance_q;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      DONE: begin
        wait_d = '0;
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_change_return_dispenser.sv
// Scenario bench for change_return_dispenser with a queue of expected return coins.
module tb_change_return_dispenser;
  import change_return_dispenser_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [kNumCoins-1:0]  i_input_coin = '0;
  logic [kNumItems-1:0]  i_select_item = '0;
  logic                  i_trigger_return = 1'b0;
  logic [kTotalBits-1:0] current_total = '0;
  logic [kNumCoins-1:0]  o_return_coin;
  logic                  o_busy;
  logic                  o_done;
  logic [kTotalBits-1:0] o_residue;
  logic [31:0]           wait_time;

  int n_cmp = 0;
  int n_bad = 0;
  logic [kNumCoins-1:0]  exp_q[$];
  logic [kTotalBits-1:0] exp_residue;

  change_return_dispenser dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_input_coin     (i_input_coin),
    .i_select_item    (i_select_item),
    .i_trigger_return (i_trigger_return),
    .current_total    (current_total),
    .o_return_coin    (o_return_coin),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_residue        (o_residue),
    .wait_time        (wait_time)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Greedy payout model: largest denomination first, remainder is residue.
  task automatic model_push(input logic [kTotalBits-1:0] total);
    logic [kTotalBits-1:0] bal;
    bal = total;
    while (bal >= 31'd1000) begin exp_q.push_back(3'b100); bal = bal - 31'd1000; end
    while (bal >= 31'd500)  begin exp_q.push_back(3'b010); bal = bal - 31'd500;  end
    while (bal >= 31'd100)  begin exp_q.push_back(3'b001); bal = bal - 31'd100;  end
    exp_residue = bal;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick;
    tick;
    n_cmp++; if (o_return_coin !== 3'b000) begin n_bad++; $display("FAIL reset_coin: got %b want 000", o_return_coin); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", o_done); end
    n_cmp++; if (o_residue !== '0) begin n_bad++; $display("FAIL reset_residue: got %0d want 0", o_residue); end
    n_cmp++; if (wait_time !== 32'd0) begin n_bad++; $display("FAIL reset_wait: got %0d want 0", wait_time); end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic run_payout(input logic [kTotalBits-1:0] total, input logic with_activity);
    int first_cyc;
    int busy_cnt;
    int n_exp;
    logic done_seen;
    logic [kNumCoins-1:0] exp_coin;
    exp_q.delete();
    model_push(total);
    n_exp = exp_q.size();
    first_cyc = -1;
    busy_cnt = 0;
    done_seen = 1'b0;
    current_total = total;
    i_trigger_return = 1'b1;
    if (with_activity) begin
      i_input_coin = 3'b001;
      i_select_item = 4'b0010;
    end
    for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
      tick;
      i_trigger_return = 1'b0;
      i_input_coin = '0;
      i_select_item = '0;
      if (cyc == 0) begin
        n_cmp++; if (o_residue !== '0) begin n_bad++; $display("FAIL residue_clear total=%0d: got %0d want 0", total, o_residue); end
      end
      if (o_busy) busy_cnt++;
      if (o_return_coin !== '0) begin
        if (first_cyc < 0) first_cyc = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL extra_coin total=%0d: got %b want none", total, o_return_coin);
        end else begin
          exp_coin = exp_q.pop_front();
          if (o_return_coin !== exp_coin) begin n_bad++; $display("FAIL coin total=%0d cyc=%0d: got %b want %b", total, cyc, o_return_coin, exp_coin); end
        end
      end
      if (o_done === 1'b1) done_seen = 1'b1;
    end
    n_cmp++; if (done_seen !== 1'b1) begin n_bad++; $display("FAIL done_timeout total=%0d: got no done want done", total); end
    if (n_exp > 0) begin
      n_cmp++; if (first_cyc !== 1) begin n_bad++; $display("FAIL latency total=%0d: got %0d want 1", total, first_cyc); end
    end
    n_cmp++; if (busy_cnt !== n_exp + 1) begin n_bad++; $display("FAIL busy_len total=%0d: got %0d want %0d", total, busy_cnt, n_exp + 1); end
    n_cmp++; if (o_residue !== exp_residue) begin n_bad++; $display("FAIL residue total=%0d: got %0d want %0d", total, o_residue, exp_residue); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL missing_coins total=%0d: got %0d left want 0", total, exp_q.size()); end
    exp_q.delete();
    current_total = '0;
    tick;
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL done_pulse total=%0d: got %b want 0", total, o_done); end
    n_cmp++; if (wait_time !== 32'd0) begin n_bad++; $display("FAIL wait_after_done total=%0d: got %0d want 0", total, wait_time); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_done total=%0d: got %b want 0", total, o_busy); end
  endtask

  task automatic test_back_to_back;
    run_payout(31'd1600, 1'b0);
    run_payout(31'd150, 1'b0);
    run_payout(31'd2100, 1'b0);
    run_payout(31'd1000, 1'b1);
    run_payout(31'd3850, 1'b0);
  endtask

  task automatic test_timeout;
    logic [kNumCoins-1:0] exp_coin;
    exp_q.delete();
    model_push(31'd500);
    current_total = 31'd500;
    for (int i = 1; i <= 10; i++) begin
      tick;
      n_cmp++; if (wait_time !== 32'(i)) begin n_bad++; $display("FAIL wait_count: got %0d want %0d", wait_time, i); end
    end
    tick;
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL timeout_start: got busy=%b want 1", o_busy); end
    n_cmp++; if (wait_time !== 32'd10) begin n_bad++; $display("FAIL wait_saturate: got %0d want 10", wait_time); end
    tick;
    exp_coin = exp_q.pop_front();
    n_cmp++; if (o_return_coin !== exp_coin) begin n_bad++; $display("FAIL timeout_coin: got %b want %b", o_return_coin, exp_coin); end
    tick;
    n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL timeout_done: got %b want 1", o_done); end
    n_cmp++; if (o_residue !== exp_residue) begin n_bad++; $display("FAIL timeout_residue: got %0d want %0d", o_residue, exp_residue); end
    current_total = '0;
    tick;
    n_cmp++; if (wait_time !== 32'd0) begin n_bad++; $display("FAIL timeout_wait_clear: got %0d want 0", wait_time); end

    current_total = 31'd500;
    for (int i = 1; i <= 7; i++) tick;
    n_cmp++; if (wait_time !== 32'd7) begin n_bad++; $display("FAIL wait_before_coin: got %0d want 7", wait_time); end
    i_input_coin = 3'b010;
    tick;
    i_input_coin = '0;
    n_cmp++; if (wait_time !== 32'd0) begin n_bad++; $display("FAIL activity_clear: got %0d want 0", wait_time); end
    for (int i = 1; i <= 10; i++) begin
      tick;
      n_cmp++; if (o_busy !== 1'b0 || o_return_coin !== '0) begin n_bad++; $display("FAIL early_payout i=%0d: got busy=%b coin=%b want 0/000", i, o_busy, o_return_coin); end
      n_cmp++; if (wait_time !== 32'(i)) begin n_bad++; $display("FAIL recount: got %0d want %0d", wait_time, i); end
    end
    current_total = '0;
    tick;
    n_cmp++; if (wait_time !== 32'd0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL zero_total_idle: got wait=%0d busy=%b want 0/0", wait_time, o_busy); end
  endtask

  task automatic test_zero_trigger;
    current_total = '0;
    i_trigger_return = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++; if (o_return_coin !== '0 || o_done !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL zero_trigger i=%0d: got coin=%b done=%b busy=%b want 000/0/0", i, o_return_coin, o_done, o_busy); end
      n_cmp++; if (wait_time !== 32'd0) begin n_bad++; $display("FAIL zero_trigger_wait: got %0d want 0", wait_time); end
    end
    i_trigger_return = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_payout;
    current_total = 31'd2100;
    i_trigger_return = 1'b1;
    tick;
    i_trigger_return = 1'b0;
    tick;
    n_cmp++; if (o_return_coin !== 3'b100) begin n_bad++; $display("FAIL mid_first_coin: got %b want 100", o_return_coin); end
    reset_n = 1'b0;
    tick;
    n_cmp++; if (o_return_coin !== '0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_out: got coin=%b busy=%b want 000/0", o_return_coin, o_busy); end
    n_cmp++; if (wait_time !== 32'd0 || o_done !== 1'b0) begin n_bad++; $display("FAIL mid_reset_wait: got wait=%0d done=%b want 0/0", wait_time, o_done); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL mid_reset_state: got %0d want 0", dut.state_q); end
    reset_n = 1'b1;
    current_total = '0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (o_return_coin !== '0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL post_reset i=%0d: got coin=%b busy=%b want 000/0", i, o_return_coin, o_busy); end
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_timeout;
    test_zero_trigger;
    test_reset_mid_payout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
